// File: rtl/key_event_if.sv
// key_event_if: key level, timing thresholds and event outputs of the key event decoder
interface key_event_if #(parameter int CNT_W = 26);
  logic             key_in;
  logic [CNT_W-1:0] long_thresh;
  logic [CNT_W-1:0] dbl_window;
  logic [CNT_W-1:0] repeat_period;
  logic             short_press;
  logic             long_press;
  logic             double_click;
  logic             repeat_pulse;
  logic             key_held;
  logic             busy;
  modport master (
    output key_in, long_thresh, dbl_window, repeat_period,
    input  short_press, long_press, double_click, repeat_pulse, key_held, busy
  );
  modport slave (
    input  key_in, long_thresh, dbl_window, repeat_period,
    output short_press, long_press, double_click, repeat_pulse, key_held, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies key presses into short/long/double events with auto-repeat
module key_event_decoder #(
  parameter int CNT_W = 26
) (
  input logic clk,
  input logic rst,
  key_event_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD} state_t;
  state_t           state, state_n;
  logic             key_prev, rise, latch;
  logic [CNT_W-1:0] cnt, cnt_n, rep_cnt, rep_cnt_n;
  logic [CNT_W-1:0] long_thresh_l, dbl_window_l, repeat_period_l;
  logic             short_n, long_n, double_n, repeat_n;
  assign rise = bus.key_in & ~key_prev;
  // Next-state, counter and strobe decode; release and second press win over threshold hits
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    rep_cnt_n = rep_cnt;
    latch = 1'b0;
    short_n = 1'b0;
    long_n = 1'b0;
    double_n = 1'b0;
    repeat_n = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = PRESS1;
          cnt_n = '0;
          latch = 1'b1;
        end
      end
      PRESS1: begin
        if (!bus.key_in) begin
          state_n = WAIT2;
          cnt_n = '0;
        end else if (cnt >= long_thresh_l) begin
          state_n = LONG_HOLD;
          long_n = 1'b1;
          rep_cnt_n = '0;
        end else cnt_n = cnt + CNT_W'(1);
      end
      WAIT2: begin
        if (bus.key_in) begin
          state_n = PRESS2;
          double_n = 1'b1;
        end else if (cnt >= dbl_window_l) begin
          state_n = IDLE;
          short_n = 1'b1;
        end else cnt_n = cnt + CNT_W'(1);
      end
      PRESS2: state_n = bus.key_in ? PRESS2 : IDLE;
      LONG_HOLD: begin
        if (!bus.key_in) state_n = IDLE;
        else if (repeat_period_l != '0 && rep_cnt >= repeat_period_l) begin
          repeat_n = 1'b1;
          rep_cnt_n = '0;
        end else rep_cnt_n = rep_cnt + CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  // State, counters, latched thresholds and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key_prev <= 1'b1;
      cnt <= '0;
      rep_cnt <= '0;
      long_thresh_l <= '0;
      dbl_window_l <= '0;
      repeat_period_l <= '0;
      bus.short_press <= 1'b0;
      bus.long_press <= 1'b0;
      bus.double_click <= 1'b0;
      bus.repeat_pulse <= 1'b0;
      bus.key_held <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      key_prev <= bus.key_in;
      cnt <= cnt_n;
      rep_cnt <= rep_cnt_n;
      if (latch) begin
        long_thresh_l <= bus.long_thresh;
        dbl_window_l <= bus.dbl_window;
        repeat_period_l <= bus.repeat_period;
      end
      bus.short_press <= short_n;
      bus.long_press <= long_n;
      bus.double_click <= double_n;
      bus.repeat_pulse <= repeat_n;
      bus.key_held <= state_n == LONG_HOLD;
      bus.busy <= state_n != IDLE;
    end
  end
endmodule
